// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic-array output path: widths, int8 limits
// and the accumulator bank control states.
package tpu_pkg;

   localparam int PSUM_W_DEF = 16;
   localparam int INT8_MAX   = 127;
   localparam int INT8_MIN   = -128;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_e;

endpackage

// File: rtl/accumulator_bank_acc_column.sv
// One systolic-array output column: two row accumulators fed alternately,
// pass counting, int8 saturation and a one-cycle store pulse per finished run.
module acc_column
   import tpu_pkg::*;
#(
   parameter int PSUM_W = PSUM_W_DEF,
   parameter int ACC_W  = PSUM_W + 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_i,
   input  logic              en_i,
   input  logic [3:0]        last_pass_i,
   input  logic [PSUM_W-1:0] psum_i,
   input  logic              valid_i,
   output logic              finished_o,
   output logic              store_o,
   output logic [7:0]        mem0_o,
   output logic [7:0]        mem1_o
);

   logic signed [ACC_W-1:0] acc0_q, acc0_d;
   logic signed [ACC_W-1:0] acc1_q, acc1_d;
   logic                    row_q, row_d;
   logic [3:0]              pass_q, pass_d;
   logic                    fin_q, fin_d;
   logic                    last_q, last_d;
   logic                    store_q, store_d;
   logic [7:0]              mem0_q, mem0_d;
   logic [7:0]              mem1_q, mem1_d;

   logic signed [ACC_W-1:0] ext;
   logic                    accept;

   function automatic logic [7:0] sat8(input logic signed [ACC_W-1:0] v);
      logic signed [ACC_W-1:0] hi;
      logic signed [ACC_W-1:0] lo;
      hi = ACC_W'(INT8_MAX);
      lo = ACC_W'(INT8_MIN);
      if (v > hi)      return 8'(INT8_MAX);
      else if (v < lo) return 8'(INT8_MIN);
      else             return v[7:0];
   endfunction

   assign ext    = ACC_W'($signed(psum_i));
   assign accept = en_i && valid_i && !fin_q && !clear_i;

   always_comb begin
      acc0_d  = acc0_q;
      acc1_d  = acc1_q;
      row_d   = row_q;
      pass_d  = pass_q;
      fin_d   = fin_q;
      last_d  = 1'b0;
      store_d = 1'b0;
      mem0_d  = mem0_q;
      mem1_d  = mem1_q;
      if (clear_i) begin
         acc0_d = '0;
         acc1_d = '0;
         row_d  = 1'b0;
         pass_d = '0;
         fin_d  = 1'b0;
      end else begin
         // last_q marks the cycle after the final accept, so both sums are complete
         if (last_q) begin
            mem0_d  = sat8(acc0_q);
            mem1_d  = sat8(acc1_q);
            store_d = 1'b1;
         end
         if (accept) begin
            if (!row_q) acc0_d = acc0_q + ext;
            else        acc1_d = acc1_q + ext;
            row_d = ~row_q;
            if (row_q) begin
               pass_d = pass_q + 4'd1;
               if (pass_q == last_pass_i) begin
                  fin_d  = 1'b1;
                  last_d = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc0_q  <= '0;
         acc1_q  <= '0;
         row_q   <= 1'b0;
         pass_q  <= '0;
         fin_q   <= 1'b0;
         last_q  <= 1'b0;
         store_q <= 1'b0;
         mem0_q  <= '0;
         mem1_q  <= '0;
      end else begin
         acc0_q  <= acc0_d;
         acc1_q  <= acc1_d;
         row_q   <= row_d;
         pass_q  <= pass_d;
         fin_q   <= fin_d;
         last_q  <= last_d;
         store_q <= store_d;
         mem0_q  <= mem0_d;
         mem1_q  <= mem1_d;
      end
   end

   assign finished_o = fin_q;
   assign store_o    = store_q;
   assign mem0_o     = mem0_q;
   assign mem1_o     = mem1_q;

endmodule

// File: rtl/accumulator_bank.sv
// Accumulator bank between the 2x2 systolic array and the unified buffer:
// run control FSM plus one accumulating column per array output column.
module accumulator_bank
   import tpu_pkg::*;
#(
   parameter int PSUM_W = PSUM_W_DEF,
   parameter int ACC_W  = PSUM_W + 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [3:0]        num_passes,
   input  logic [PSUM_W-1:0] psum0,
   input  logic              psum0_valid,
   input  logic [PSUM_W-1:0] psum1,
   input  logic              psum1_valid,
   output logic [7:0]        a1_mem_0,
   output logic [7:0]        a1_mem_1,
   output logic [7:0]        a2_mem_0,
   output logic [7:0]        a2_mem_1,
   output logic              store_a1,
   output logic              store_a2,
   output logic              busy,
   output logic              done
);

   state_e     state_q, state_d;
   logic [3:0] last_pass_q, last_pass_d;
   logic       done_q, done_d;
   logic       col_en;
   logic       fin0, fin1;

   // start always wins over valids, so columns only accept on non-start cycles
   assign col_en = (state_q == ACCUM) && !start;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         last_pass_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_pass_q <= last_pass_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      last_pass_d = last_pass_q;
      done_d      = 1'b0;
      if (start) begin
         state_d     = ACCUM;
         last_pass_d = (num_passes == 4'd0) ? 4'd0 : num_passes - 4'd1;
      end else if (state_q == ACCUM && fin0 && fin1) begin
         state_d = IDLE;
         done_d  = 1'b1;
      end
   end

   always_comb begin
      busy = (state_q == ACCUM);
      done = done_q;
   end

   acc_column #(.PSUM_W(PSUM_W), .ACC_W(ACC_W)) u_col0 (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (start),
      .en_i        (col_en),
      .last_pass_i (last_pass_q),
      .psum_i      (psum0),
      .valid_i     (psum0_valid),
      .finished_o  (fin0),
      .store_o     (store_a1),
      .mem0_o      (a1_mem_0),
      .mem1_o      (a1_mem_1)
   );

   acc_column #(.PSUM_W(PSUM_W), .ACC_W(ACC_W)) u_col1 (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (start),
      .en_i        (col_en),
      .last_pass_i (last_pass_q),
      .psum_i      (psum1),
      .valid_i     (psum1_valid),
      .finished_o  (fin1),
      .store_o     (store_a2),
      .mem0_o      (a2_mem_0),
      .mem1_o      (a2_mem_1)
   );

endmodule

// File: tb/tb_accumulator_bank.sv
// Bench for accumulator_bank: directed and randomized runs checked against
// per-run sums of the psum streams, saturated to int8.
module tb_accumulator_bank;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  num_passes = '0;
   logic [15:0] psum0 = '0;
   logic        psum0_valid = 1'b0;
   logic [15:0] psum1 = '0;
   logic        psum1_valid = 1'b0;
   logic [7:0]  a1_mem_0, a1_mem_1, a2_mem_0, a2_mem_1;
   logic        store_a1, store_a2, busy, done;

   int checks = 0;
   int errors = 0;
   int v0[$];
   int v1[$];
   logic [7:0] pm[4];

   accumulator_bank #(.PSUM_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .num_passes(num_passes),
      .psum0(psum0), .psum0_valid(psum0_valid),
      .psum1(psum1), .psum1_valid(psum1_valid),
      .a1_mem_0(a1_mem_0), .a1_mem_1(a1_mem_1),
      .a2_mem_0(a2_mem_0), .a2_mem_1(a2_mem_1),
      .store_a1(store_a1), .store_a2(store_a2), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] sat8(input int v);
      if (v > 127)  return 8'h7F;
      if (v < -128) return 8'h80;
      return 8'(v);
   endfunction

   task automatic fill_rand(input int np, input int amp);
      int n;
      n = (np == 0) ? 2 : 2 * np;
      v0.delete();
      v1.delete();
      for (int k = 0; k < n; k++) begin
         v0.push_back(int'($urandom_range(0, 2 * amp)) - amp);
         v1.push_back(int'($urandom_range(0, 2 * amp)) - amp);
      end
   endtask

   // One complete run: start (with junk valids that must be dropped), stream
   // v0/v1 with optional gaps and column-1 skew, junk valids after each column
   // finishes, and a cycle-by-cycle check of strobes, busy and mem buses.
   task automatic do_run(input string name, input int np, input bit gaps, input int skew1);
      int n, i0, i1, f0, f1, last, lim;
      int s[2][2];
      logic [7:0] e[4];
      logic [3:0] exp_ctl;
      logic [15:0] exp_a1, exp_a2;
      bit finished;
      n = (np == 0) ? 2 : 2 * np;
      s = '{default: 0};
      for (int k = 0; k < n; k++) begin
         s[0][k % 2] += v0[k];
         s[1][k % 2] += v1[k];
      end
      e[0] = sat8(s[0][0]); e[1] = sat8(s[0][1]);
      e[2] = sat8(s[1][0]); e[3] = sat8(s[1][1]);
      @(negedge clk);
      start = 1'b1; num_passes = 4'(np);
      psum0_valid = 1'b1; psum0 = 16'($urandom);
      psum1_valid = 1'b1; psum1 = 16'($urandom);
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({store_a1, store_a2, done, busy} !== 4'b0001 ||
          {a1_mem_0, a1_mem_1, a2_mem_0, a2_mem_1} !== {pm[0], pm[1], pm[2], pm[3]}) begin
         errors++;
         $display("FAIL %s start_edge ctl=%b mems=%h exp ctl=0001 mems=%h", name,
                  {store_a1, store_a2, done, busy}, {a1_mem_0, a1_mem_1, a2_mem_0, a2_mem_1},
                  {pm[0], pm[1], pm[2], pm[3]});
      end
      i0 = 0; i1 = 0; f0 = -1; f1 = -1; finished = 1'b0;
      lim = 4 * n + skew1 + 20;
      for (int t = 1; t <= lim; t++) begin
         if (i0 < n && (!gaps || $urandom_range(0, 2) != 0)) begin
            psum0_valid = 1'b1; psum0 = 16'(v0[i0]);
            if (i0 == n - 1) f0 = t;
            i0++;
         end else begin
            psum0_valid = (i0 >= n) ? 1'($urandom_range(0, 1)) : 1'b0;
            psum0 = 16'($urandom);
         end
         if (t > skew1 && i1 < n && (!gaps || $urandom_range(0, 2) != 0)) begin
            psum1_valid = 1'b1; psum1 = 16'(v1[i1]);
            if (i1 == n - 1) f1 = t;
            i1++;
         end else begin
            psum1_valid = (i1 >= n) ? 1'($urandom_range(0, 1)) : 1'b0;
            psum1 = 16'($urandom);
         end
         @(negedge clk);
         last = (f0 >= 0 && f1 >= 0) ? ((f0 > f1) ? f0 : f1) : -1;
         exp_ctl = {f0 >= 0 && t == f0 + 1, f1 >= 0 && t == f1 + 1,
                    last >= 0 && t == last + 1, !(last >= 0 && t > last)};
         exp_a1 = (f0 >= 0 && t > f0) ? {e[0], e[1]} : {pm[0], pm[1]};
         exp_a2 = (f1 >= 0 && t > f1) ? {e[2], e[3]} : {pm[2], pm[3]};
         checks++;
         if ({store_a1, store_a2, done, busy} !== exp_ctl) begin
            errors++;
            $display("FAIL %s ctl t=%0d store1,store2,done,busy=%b exp %b", name, t,
                     {store_a1, store_a2, done, busy}, exp_ctl);
         end
         checks++;
         if ({a1_mem_0, a1_mem_1} !== exp_a1) begin
            errors++;
            $display("FAIL %s a1_mem t=%0d got %h exp %h", name, t, {a1_mem_0, a1_mem_1}, exp_a1);
         end
         checks++;
         if ({a2_mem_0, a2_mem_1} !== exp_a2) begin
            errors++;
            $display("FAIL %s a2_mem t=%0d got %h exp %h", name, t, {a2_mem_0, a2_mem_1}, exp_a2);
         end
         if (last >= 0 && t > last) begin
            finished = 1'b1;
            break;
         end
      end
      checks++;
      if (!finished) begin
         errors++;
         $display("FAIL %s timeout fed0=%0d fed1=%0d required %0d each", name, i0, i1, n);
      end
      psum0_valid = 1'b0; psum1_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({store_a1, store_a2, done, busy} !== 4'b0000 ||
          {a1_mem_0, a1_mem_1, a2_mem_0, a2_mem_1} !== {e[0], e[1], e[2], e[3]}) begin
         errors++;
         $display("FAIL %s after_run ctl=%b mems=%h exp ctl=0000 mems=%h", name,
                  {store_a1, store_a2, done, busy}, {a1_mem_0, a1_mem_1, a2_mem_0, a2_mem_1},
                  {e[0], e[1], e[2], e[3]});
      end
      for (int k = 0; k < 4; k++) pm[k] = e[k];
   endtask

   task automatic check_quiet(input string name, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         psum0_valid = 1'($urandom_range(0, 1)); psum0 = 16'($urandom);
         psum1_valid = 1'($urandom_range(0, 1)); psum1 = 16'($urandom);
         @(negedge clk);
         checks++;
         if ({store_a1, store_a2, done, busy} !== 4'b0000 ||
             {a1_mem_0, a1_mem_1, a2_mem_0, a2_mem_1} !== {pm[0], pm[1], pm[2], pm[3]}) begin
            errors++;
            $display("FAIL %s cycle %0d ctl=%b mems=%h exp ctl=0000 mems=%h", name, c,
                     {store_a1, store_a2, done, busy}, {a1_mem_0, a1_mem_1, a2_mem_0, a2_mem_1},
                     {pm[0], pm[1], pm[2], pm[3]});
         end
      end
      psum0_valid = 1'b0; psum1_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 4; k++) pm[k] = 8'h00;
      checks++;
      if ({store_a1, store_a2, done, busy} !== 4'b0000 ||
          {a1_mem_0, a1_mem_1, a2_mem_0, a2_mem_1} !== 32'h0) begin
         errors++;
         $display("FAIL reset ctl=%b mems=%h exp all zero", {store_a1, store_a2, done, busy},
                  {a1_mem_0, a1_mem_1, a2_mem_0, a2_mem_1});
      end
      rst = 1'b0;
      check_quiet("idle_valids", 5);
   endtask

   task automatic test_single_pass();
      v0 = '{5, -3};
      v1 = '{100, 27};
      do_run("single_pass", 1, 1'b0, 0);
   endtask

   task automatic test_saturation();
      v0 = '{100, -100, 100, -100, 100, -100};
      v1 = '{-32768, 32767, -32768, 32767, -32768, 32767};
      do_run("saturation", 3, 1'b0, 0);
   endtask

   task automatic test_skew();
      fill_rand(2, 50);
      do_run("skew", 2, 1'b0, 4);
   endtask

   task automatic test_restart();
      @(negedge clk);
      start = 1'b1; num_passes = 4'd2;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 3; c++) begin
         psum0_valid = 1'b1; psum0 = 16'($urandom_range(0, 200));
         psum1_valid = 1'b1; psum1 = 16'($urandom_range(0, 200));
         @(negedge clk);
         checks++;
         if ({store_a1, store_a2, done, busy} !== 4'b0001) begin
            errors++;
            $display("FAIL restart_abort cycle %0d ctl=%b exp 0001", c,
                     {store_a1, store_a2, done, busy});
         end
      end
      v0 = '{1, 2, 3, 4};
      v1 = '{-7, 9, 11, -13};
      do_run("restart", 2, 1'b0, 0);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      start = 1'b1; num_passes = 4'd3;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 5; c++) begin
         psum0_valid = 1'b1; psum0 = 16'($urandom);
         psum1_valid = 1'b1; psum1 = 16'($urandom);
         @(negedge clk);
      end
      rst = 1'b1;
      psum0_valid = 1'b1; psum1_valid = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) pm[k] = 8'h00;
      checks++;
      if ({store_a1, store_a2, done, busy} !== 4'b0000 ||
          {a1_mem_0, a1_mem_1, a2_mem_0, a2_mem_1} !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid ctl=%b mems=%h exp all zero", {store_a1, store_a2, done, busy},
                  {a1_mem_0, a1_mem_1, a2_mem_0, a2_mem_1});
      end
      check_quiet("after_reset_mid", 4);
      fill_rand(0, 60);
      do_run("np_zero", 0, 1'b1, 1);
   endtask

   task automatic test_random();
      int np;
      for (int r = 0; r < 10; r++) begin
         np = $urandom_range(0, 15);
         fill_rand(np, (r % 2 == 0) ? 32768 : 40);
         do_run("random", np, 1'b1, $urandom_range(0, 6));
      end
   endtask

   task automatic test_back_to_back();
      fill_rand(1, 90);
      do_run("b2b_a", 1, 1'b0, 0);
      fill_rand(4, 20);
      do_run("b2b_b", 4, 1'b1, 2);
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_saturation();
      test_skew();
      test_restart();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/accumulator_bank.md
Name: accumulator_bank

Overview:
- Sits directly upstream of the unified buffer.
- Receives signed partial sums from the two output columns of the 2x2 systolic array and accumulates them over a programmable number of passes.
- Saturates each final sum to signed int8 and presents it on the a1/a2 memory buses, one store pulse per column.
- Column 0 feeds the a1 bus and column 1 feeds the a2 bus. Row 0 goes to the _mem_0 slot and row 1 to the _mem_1 slot.

Parameters:
- PSUM_W, 16: width of the signed partial sum from each array column.
- ACC_W, PSUM_W+4: internal signed accumulator width. Holds 15 passes of full-scale input with no overflow.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse: clear all accumulators, latch num_passes, enter ACCUM.
- num_passes  input  4  number of passes to accumulate. 0 is treated as 1. Sampled only when start is high.
- psum0  input  PSUM_W  signed partial sum, column 0.
- psum0_valid  input  1  psum0 is valid this cycle.
- psum1  input  PSUM_W  signed partial sum, column 1.
- psum1_valid  input  1  psum1 is valid this cycle.
- a1_mem_0  output  8  column 0, row 0 result, signed int8 saturated.
- a1_mem_1  output  8  column 0, row 1 result.
- a2_mem_0  output  8  column 1, row 0 result.
- a2_mem_1  output  8  column 1, row 1 result.
- store_a1  output  1  one-cycle pulse: a1_mem_* valid, to be written downstream.
- store_a2  output  1  one-cycle pulse: a2_mem_* valid.
- busy  output  1  high in ACCUM.
- done  output  1  one-cycle pulse when both columns have stored.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (ports clk and rst). All state updates on the rising clk edge.
- Reset (rst high at an edge):
  - All outputs go to 0.
  - State goes to IDLE.
  - Accumulators, row indices and pass counters are cleared.
  - rst has priority over start and over valids. Reset mid-accumulation discards all partial results and produces no store pulse.
- States:
  - IDLE: valids ignored. start moves to ACCUM.
  - ACCUM: busy=1. When both columns have finished, move to IDLE and pulse done on that same edge.
- Per-column logic (columns are independent and may be skewed by any number of cycles):
  - row_idx: 1 bit, starts at 0. pass_cnt: 4 bits, starts at 0.
  - On valid in ACCUM with the column not finished: acc[row_idx] += sign_extend(psum). row_idx then toggles.
  - When row_idx goes 1->0, pass_cnt increments.
  - Accepting row 1 of pass (num_passes-1) marks the column finished. Further valids for that column are ignored until the next start.
  - On the edge after the final accept:
    - Register sat8(acc[0]) and sat8(acc[1]), both including the final addend, onto the column's mem outputs.
    - store_aX = 1 for exactly one cycle.
  - Latency: final psum accepted at edge N gives outputs and store visible after edge N+1.
- sat8: value > 127 gives 127 (0x7F); value < -128 gives -128 (0x80); otherwise the low 8 bits. Two's complement throughout.
- mem outputs hold their value until the next store for that column or a reset. start does not clear them.
- start in ACCUM: restart. Clears accumulators, row indices, pass counts and finished flags, and relatches num_passes. No store or done is produced for the aborted run.
- start coincident with a valid: start wins and the valid is dropped.
- store_a1 and store_a2 may assert in the same cycle.
- done asserts on the edge after the later of the two final accepts, i.e. coincident with the later store pulse.

Decomposition:
- Shared package tpu_pkg holds:
  - PSUM_W default;
  - INT8_MAX=127 and INT8_MIN=-128;
  - the state enum (IDLE, ACCUM).
- One sub-module is natural: acc_column. It holds the two row accumulators, row_idx, pass_cnt, finished flag, saturation and store pulse. It is instantiated twice.
- The top holds the FSM and the done/busy logic.

Test Plan:
- rst high 2 cycles, then idle -> all outputs 0, busy=0. psum valids in IDLE -> no change.
- start num_passes=1; col0 psums 5, -3; col1 psums 100, 27 on the same cycles -> one cycle later store_a1=store_a2=1 and done=1; a1=(0x05,0xFD), a2=(0x64,0x1B); busy falls.
- num_passes=3, col0 row0 sends 100 three times (sum 300) and row1 sends -100 three times (sum -300) -> a1_mem_0=0x7F, a1_mem_1=0x80.
- Skew: col1 final psum arrives 4 cycles after col0 -> store_a1 is 4 cycles before store_a2; done is coincident with store_a2; a1_mem values stay stable throughout.
- start mid-run after 1 of 2 passes, then a full 2-pass run with values 1,2,3,4 -> a1=(4,6); no store pulse from the aborted run.
- rst asserted mid-ACCUM together with psum valid -> next cycle state IDLE, outputs 0, no store pulse. num_passes=0 behaves as 1.
